logic_op_arbiter: RTL

//   Shares one WIDTH-bit bitwise logic unit (AND/OR/XOR/NOT/NAND/NOR/XNOR) among NREQ requesters.
//   - Round-robin arbitration picks one requester; its opcode and operands are registered.
//   - The result is computed and returned with the requester ID over a valid/ready response port.
//   - Sits between several control agents and a single shared logic datapath, so the gates are not replicated.

---
 rtl/logic_op_arbiter.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/logic_op_arbiter.sv
// Round-robin arbiter sharing one bitwise logic unit among NREQ requesters.
// Each accepted request is executed once and answered over a valid/ready response port.
module logic_op_arbiter #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NREQ-1:0]              req_valid,
    output logic [NREQ-1:0]              req_ready,
    input  logic [3*NREQ-1:0]            req_op,
    input  logic [WIDTH*NREQ-1:0]        req_x,
    input  logic [WIDTH*NREQ-1:0]        req_y,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] rsp_id,
    output logic [WIDTH-1:0]             rsp_data,
    output logic                         rsp_err,
    output logic                         busy
);

    localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [IDW:0]   NREQ_W  = (IDW+1)'(NREQ);
    localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_XOR  = 3'd2;
    localparam logic [2:0] OP_NOT  = 3'd3;
    localparam logic [2:0] OP_NAND = 3'd4;
    localparam logic [2:0] OP_NOR  = 3'd5;
    localparam logic [2:0] OP_XNOR = 3'd6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state;
    logic [IDW-1:0]     rr_ptr;
    logic [IDW-1:0]     id_q;
    logic [2:0]         op_q;
    logic [WIDTH-1:0]   x_q;
    logic [WIDTH-1:0]   y_q;

    logic               grant_vld;
    logic [IDW-1:0]     grant_id;
    logic [IDW:0]       idx_w;
    logic [2:0]         sel_op;
    logic [WIDTH-1:0]   sel_x;
    logic [WIDTH-1:0]   sel_y;
    logic [WIDTH-1:0]   alu_data;
    logic               alu_err;

    // First valid requester at or after rr_ptr, wrapping around.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        idx_w     = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx_w = {1'b0, rr_ptr} + (IDW+1)'(k);
            if (idx_w >= NREQ_W) begin
                idx_w = idx_w - NREQ_W;
            end
            if (!grant_vld && req_valid[idx_w[IDW-1:0]]) begin
                grant_vld = 1'b1;
                grant_id  = idx_w[IDW-1:0];
            end
        end
    end

    // Grant is offered only in IDLE and never while reset is held.
    always_comb begin
        req_ready = '0;
        if ((state == IDLE) && !rst && grant_vld) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    // Payload of the granted requester.
    always_comb begin
        sel_op = '0;
        sel_x  = '0;
        sel_y  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant_id == IDW'(i)) begin
                sel_op = req_op[3*i +: 3];
                sel_x  = req_x[WIDTH*i +: WIDTH];
                sel_y  = req_y[WIDTH*i +: WIDTH];
            end
        end
    end

    // Shared logic unit, fed only from the captured operands.
    always_comb begin
        alu_data = '0;
        alu_err  = 1'b0;
        case (op_q)
            OP_AND:  alu_data = x_q & y_q;
            OP_OR:   alu_data = x_q | y_q;
            OP_XOR:  alu_data = x_q ^ y_q;
            OP_NOT:  alu_data = ~x_q;
            OP_NAND: alu_data = ~(x_q & y_q);
            OP_NOR:  alu_data = ~(x_q | y_q);
            OP_XNOR: alu_data = ~(x_q ^ y_q);
            default: begin
                alu_data = '0;
                alu_err  = 1'b1;
            end
        endcase
    end

    // Control FSM with registered response and busy outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            id_q      <= '0;
            op_q      <= '0;
            x_q       <= '0;
            y_q       <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        id_q   <= grant_id;
                        op_q   <= sel_op;
                        x_q    <= sel_x;
                        y_q    <= sel_y;
                        rr_ptr <= (grant_id == LAST_ID) ? '0 : grant_id + IDW'(1);
                        state  <= EXEC;
                        busy   <= 1'b1;
                    end
                end
                EXEC: begin
                    rsp_data  <= alu_data;
                    rsp_err   <= alu_err;
                    rsp_id    <= id_q;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
